// File: rtl/quad_mux_arb_pkg.sv
// Shared types, requester indices and helpers for the quad_mux_arb round-robin arbiter.
package quad_mux_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    localparam int DEFAULT_MAX_BURST = 4;

    // First requesting index found scanning last+1, last+2, ... with 2-bit wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + i[1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_quad4_1.sv
// Quad 4-to-1 multiplexer: four bit-slices sharing one 2-bit select.
module mux_quad4_1 (
    input  logic [1:0] S,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    output logic [3:0] Y
);

    always_comb begin
        unique case (S)
            2'd0:    Y = A;
            2'd1:    Y = B;
            2'd2:    Y = C;
            default: Y = D;
        endcase
    end

endmodule

// File: rtl/quad_mux_arb.sv
// Round-robin arbiter driving a shared quad 4-1 mux into a one-entry valid/ready output stage.
// Optional burst mode (same owner re-wins up to MAX_BURST times) enabled by QUAD_MUX_ARB_BURST_EN.
module quad_mux_arb
    import quad_mux_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] InA,
    input  logic [3:0] InB,
    input  logic [3:0] InC,
    input  logic [3:0] InD,
    output logic [3:0] ack,
    output logic [3:0] grant,
    output logic [1:0] S,
    output logic [3:0] Out,
    output logic       out_valid,
    input  logic       out_ready
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("quad_mux_arb: MAX_BURST must be in 1..15");
    end

    arb_state_e state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] s_q, s_d;
    logic [3:0] out_q, out_d;
    logic       vld_q, vld_d;
    logic [3:0] ack_q, ack_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] win;
    logic [3:0] mux_y;

    mux_quad4_1 u_mux (
        .S (win),
        .A (InA),
        .B (InB),
        .C (InC),
        .D (InD),
        .Y (mux_y)
    );

`ifdef QUAD_MUX_ARB_BURST_EN
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic [3:0] cnt_q, cnt_d;
    logic       keep_owner;

    assign keep_owner = req[last_q] && (cnt_q < BURST_LIM);

    always_comb begin
        win = rr_pick(req, last_q);
        if (keep_owner) begin
            win = last_q;
        end
    end

    // A repeat win only extends the burst while under the limit; any other grant starts a new one.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE && |req) begin
            cnt_d = (win == last_q && cnt_q < BURST_LIM) ? cnt_q + 4'd1 : 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        win = rr_pick(req, last_q);
    end
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        s_d     = s_q;
        out_d   = out_q;
        vld_d   = vld_q;
        ack_d   = 4'b0000;
        grant_d = grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    out_d   = mux_y;
                    vld_d   = 1'b1;
                    s_d     = win;
                    grant_d = onehot4(win);
                    ack_d   = onehot4(win);
                    last_d  = win;
                    state_d = ARB_BUSY;
                end
            end
            default: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    grant_d = 4'b0000;
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= REQ_D;
            s_q     <= REQ_A;
            out_q   <= 4'd0;
            vld_q   <= 1'b0;
            ack_q   <= 4'b0000;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
        end
    end

    assign ack       = ack_q;
    assign grant     = grant_q;
    assign S         = s_q;
    assign Out       = out_q;
    assign out_valid = vld_q;

endmodule
